// File: rtl/fos_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : fos_sched_pkg
// Purpose  : Shared types and widths for the time-multiplexed first-order IIR
//            scheduler: FSM state encoding, sample width and coefficient width.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fos_sched_pkg;

   localparam int DW = 32;   // sample / state / result width
   localparam int KW = 11;   // signed coefficient width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      MULB = 2'd2,
      MULA = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/rad4_reference2.sv
//------------------------------------------------------------------------------
// Module   : rad4_reference2
// Purpose  : Combinational signed multiplier, radix-4 Booth recoded, returning
//            the low AW bits of signed(AW) x signed(BW). No saturation.
// Ports    : a_i  [AW-1:0]  multiplicand, two's complement
//            b_i  [BW-1:0]  multiplier, two's complement
//            p_o  [AW-1:0]  low AW bits of the product
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rad4_reference2 #(
   parameter int AW = 32,
   parameter int BW = 11
) (
   input  logic [AW-1:0] a_i,
   input  logic [BW-1:0] b_i,
   output logic [AW-1:0] p_o
);

   // One extra digit so the sign-extended multiplier is always fully covered,
   // whether BW is odd or even.
   localparam int ND = BW / 2 + 1;

   // Sign-extended multiplier with the implicit zero below bit 0.
   logic [2*ND:0]  bx_w;
   logic [AW-1:0]  pp_w;
   logic [AW-1:0]  sum_w;

   assign bx_w = {{(2*ND-BW){b_i[BW-1]}}, b_i, 1'b0};

   always_comb begin
      pp_w  = '0;
      sum_w = '0;
      for (int i = 0; i < ND; i++) begin
         case (bx_w[2*i +: 3])
            3'b001, 3'b010: pp_w = a_i;
            3'b011:         pp_w = a_i << 1;
            3'b100:         pp_w = -(a_i << 1);
            3'b101, 3'b110: pp_w = -a_i;
            default:        pp_w = '0;
         endcase
         sum_w = sum_w + (pp_w << (2*i));
      end
   end

   assign p_o = sum_w;

endmodule

`default_nettype wire

// File: rtl/fos_mux_sched.sv
//------------------------------------------------------------------------------
// Module   : fos_mux_sched
// Purpose  : Runs NCH first-order transposed-form IIR sections
//            (y = x + s, s' = b1*x + a1*y) through one shared 32x11 multiplier.
// Ports    : clk, reset (async, active low)
//            in_valid/in_ready/in_ch/in_data     sample input stream
//            out_valid/out_ready/out_ch/out_data result output stream
//            cfg_we/cfg_ch/cfg_a1/cfg_b1         coefficient write port
//            flush                               zero all s[] (IDLE only)
//            busy                                FSM not in IDLE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fos_mux_sched
   import fos_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ch,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_ch,
   output logic [DW-1:0] out_data,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [KW-1:0] cfg_a1,
   input  logic [KW-1:0] cfg_b1,
   input  logic          flush,
   output logic          busy
);

   state_e        state_q;

   // Per-channel storage as flop arrays so reset and flush hit every channel.
   logic [KW-1:0] a1_q [NCH];
   logic [KW-1:0] b1_q [NCH];
   logic [DW-1:0] s_q  [NCH];

   // Working registers for the sample in flight; coefficients are snapshotted
   // at accept so later cfg writes cannot disturb it.
   logic [DW-1:0] x_q;
   logic [CW-1:0] ch_q;
   logic [KW-1:0] ka_q;
   logic [KW-1:0] kb_q;
   logic [DW-1:0] acc_q;

   logic          out_valid_q;
   logic [CW-1:0] out_ch_q;
   logic [DW-1:0] out_data_q;

   logic [DW-1:0] y_d;
   logic          out_free_d;
   logic [DW-1:0] mul_a_d;
   logic [KW-1:0] mul_b_d;
   logic [DW-1:0] mul_p_d;

   assign y_d        = x_q + s_q[ch_q];
   // Output register can take a new result if empty or draining this cycle.
   assign out_free_d = !out_valid_q || out_ready;

   // y is still held in out_data_q during MULA: the output register is only
   // ever loaded in ADD, and draining does not alter its contents.
   assign mul_a_d = (state_q == MULA) ? out_data_q : x_q;
   assign mul_b_d = (state_q == MULA) ? ka_q       : kb_q;

   rad4_reference2 #(
      .AW (DW),
      .BW (KW)
   ) u_mul (
      .a_i (mul_a_d),
      .b_i (mul_b_d),
      .p_o (mul_p_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         for (int k = 0; k < NCH; k++) begin
            a1_q[k] <= '0;
            b1_q[k] <= '0;
            s_q[k]  <= '0;
         end
         x_q         <= '0;
         ch_q        <= '0;
         ka_q        <= '0;
         kb_q        <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
      end else begin
         if (cfg_we) begin
            a1_q[cfg_ch] <= cfg_a1;
            b1_q[cfg_ch] <= cfg_b1;
         end

         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               // Flush lands on the same edge as an accept; s[] is only read
               // in ADD, so the accepted sample already sees the zeroed state.
               if (flush) begin
                  for (int k = 0; k < NCH; k++) begin
                     s_q[k] <= '0;
                  end
               end
               if (in_valid) begin
                  x_q     <= in_data;
                  ch_q    <= in_ch;
                  ka_q    <= a1_q[in_ch];
                  kb_q    <= b1_q[in_ch];
                  state_q <= ADD;
               end
            end
            ADD: begin
               if (out_free_d) begin
                  out_data_q  <= y_d;
                  out_ch_q    <= ch_q;
                  out_valid_q <= 1'b1;
                  state_q     <= MULB;
               end
            end
            MULB: begin
               acc_q   <= mul_p_d;
               state_q <= MULA;
            end
            MULA: begin
               s_q[ch_q] <= acc_q + mul_p_d;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;

endmodule

`default_nettype wire
